// File: rtl/button_debounce_pulser.sv
// Per-bit two-flop synchroniser, stability-count debouncer and registered
// press/release pulse generator with a lowest-index press encoder.
module button_debounce_pulser #(
   parameter int WIDTH           = 24,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
   parameter int IDX_W           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] buttons_raw,
   output logic [WIDTH-1:0] buttons_stable,
   output logic [WIDTH-1:0] buttons_pressed,
   output logic [WIDTH-1:0] buttons_released,
   output logic             any_pressed,
   output logic [IDX_W-1:0] press_index
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("button_debounce_pulser: DEBOUNCE_CYCLES must be at least 1");
   end

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_p0;
   logic [WIDTH-1:0] sync_p1;
   logic [CNT_W-1:0] cnt     [WIDTH];
   logic [CNT_W-1:0] cnt_nxt [WIDTH];
   logic [WIDTH-1:0] stable_nxt;
   logic [WIDTH-1:0] pressed_nxt;
   logic [WIDTH-1:0] released_nxt;

   // Bit 0 has the highest priority, so the last match scanning downward wins.
   function automatic logic [IDX_W-1:0] lowest_index(input logic [WIDTH-1:0] vec);
      lowest_index = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) lowest_index = IDX_W'(i);
      end
   endfunction

   always_comb begin
      cnt_nxt      = cnt;
      stable_nxt   = buttons_stable;
      pressed_nxt  = '0;
      released_nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync_p1[i] == buttons_stable[i]) begin
            cnt_nxt[i] = '0;
         end else if (cnt[i] < CNT_MAX) begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
         end else begin
            cnt_nxt[i]      = '0;
            stable_nxt[i]   = sync_p1[i];
            pressed_nxt[i]  = sync_p1[i];
            released_nxt[i] = ~sync_p1[i];
         end
      end
   end

   // Stage p0/p1: synchroniser; then debounce state and registered pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0          <= '0;
         sync_p1          <= '0;
         buttons_stable   <= '0;
         buttons_pressed  <= '0;
         buttons_released <= '0;
         any_pressed      <= 1'b0;
         press_index      <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         sync_p0          <= buttons_raw;
         sync_p1          <= sync_p0;
         buttons_stable   <= stable_nxt;
         buttons_pressed  <= pressed_nxt;
         buttons_released <= released_nxt;
         any_pressed      <= |pressed_nxt;
         press_index      <= lowest_index(pressed_nxt);
         for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      end
   end

endmodule
